// File: rtl/equilibrium_maxxing_uc.sv
// equilibrium_maxxing_uc -- control unit for the EquilibriumMaxxing datapath.
// Sequences calibrate -> level select -> prep -> rounds -> win/lose and drives
// every strobe the datapath consumes. Outputs are registered copies of the
// decode of the next state, so they line up with the registered state code.
// Optional attract mode: define EQUILIBRIUM_ATTRACT_MODE_EN.
module equilibrium_maxxing_uc #(
  parameter logic [7:0] PONTOS_VITORIA = 8'd10,
  parameter int         VIDAS          = 3,
  parameter int         CAL_TIMEOUT    = 250_000_000,
  parameter int         ATTRACT_PERIOD = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       end_left,
  input  logic       end_right,
  input  logic       prep_done,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  input  logic [7:0] pontuacao,
  output logic       calib,
  output logic       start_game,
  output logic       gerar_nova_jogada,
  output logic       fade_trigger,
  output logic       conta_nivel,
  output logic       reset_nivel,
  output logic       reset_nivel_locked,
  output logic       reset_prep_cnt,
  output logic       trava_servo,
  output logic       external,
  output logic [1:0] vidas,
  output logic       venceu,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    CALIBRA    = 4'd1,
    SELECIONA  = 4'd2,
    TRAVA      = 4'd3,
    PREPARA    = 4'd4,
    GERA       = 4'd5,
    FADE       = 4'd6,
    JOGANDO    = 4'd7,
    PONTO      = 4'd8,
    CHECA      = 4'd9,
    ERROU      = 4'd10,
    FIM_VENCEU = 4'd11,
    FIM_PERDEU = 4'd12,
    ERRO       = 4'd15
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        iniciar_q;
  logic        iniciar_rise;
  logic [31:0] cal_cnt;
  logic        attract_fire;
  logic        attract_fade_pend;

  // iniciar_q resets high so a button held through reset does not fire
  assign iniciar_rise = iniciar & ~iniciar_q;
  assign db_estado    = state;

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      INICIAL:   if (iniciar_rise) state_next = CALIBRA;
      CALIBRA: begin
        // an end-switch wins over a timeout on the same cycle
        if (end_left | end_right)                 state_next = SELECIONA;
        else if (cal_cnt == 32'(CAL_TIMEOUT - 1)) state_next = ERRO;
      end
      SELECIONA: if (iniciar_rise) state_next = TRAVA;
      TRAVA:     state_next = PREPARA;
      PREPARA:   if (prep_done) state_next = GERA;
      GERA:      state_next = FADE;
      FADE:      state_next = JOGANDO;
      JOGANDO: begin
        if (ganhou_ponto)      state_next = PONTO;
        else if (perdeu_ponto) state_next = ERROU;
      end
      PONTO:     state_next = CHECA;
      // score is re-sampled here, one cycle after conta_nivel bumped it
      CHECA:     state_next = (pontuacao >= PONTOS_VITORIA) ? FIM_VENCEU : GERA;
      ERROU:     state_next = (vidas <= 2'd1) ? FIM_PERDEU : GERA;
      FIM_VENCEU, FIM_PERDEU, ERRO:
                 if (iniciar_rise) state_next = INICIAL;
      default:   state_next = INICIAL;
    endcase
  end

  // State, counters and registered output decode
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= INICIAL;
      iniciar_q          <= 1'b1;
      cal_cnt            <= '0;
      vidas              <= 2'(VIDAS);
      calib              <= 1'b0;
      start_game         <= 1'b0;
      gerar_nova_jogada  <= 1'b0;
      fade_trigger       <= 1'b0;
      conta_nivel        <= 1'b0;
      reset_nivel        <= 1'b1;
      reset_nivel_locked <= 1'b1;
      reset_prep_cnt     <= 1'b0;
      trava_servo        <= 1'b0;
      venceu             <= 1'b0;
      perdeu             <= 1'b0;
    end else begin
      state     <= state_next;
      iniciar_q <= iniciar;
      cal_cnt   <= (state == CALIBRA) ? cal_cnt + 32'd1 : '0;
      if (state == INICIAL)
        vidas <= 2'(VIDAS);
      else if ((state == ERROU) && (vidas != 2'd0))
        vidas <= vidas - 2'd1;
      calib              <= (state_next == CALIBRA);
      start_game         <= (state_next == TRAVA);
      gerar_nova_jogada  <= (state_next == GERA) | attract_fire;
      fade_trigger       <= (state_next == FADE) | (attract_fade_pend & (state_next == INICIAL));
      conta_nivel        <= (state_next == PONTO);
      reset_nivel        <= (state_next == INICIAL);
      reset_nivel_locked <= (state_next == INICIAL);
      reset_prep_cnt     <= (state_next == TRAVA);
      trava_servo        <= (state_next == PREPARA) | (state_next == FIM_VENCEU) |
                            (state_next == FIM_PERDEU) | (state_next == ERRO);
      venceu             <= (state_next == FIM_VENCEU);
      perdeu             <= (state_next == FIM_PERDEU);
    end
  end

`ifdef EQUILIBRIUM_ATTRACT_MODE_EN
  logic [31:0] attract_cnt;
  logic        stay_inicial;

  assign stay_inicial = (state == INICIAL) && (state_next == INICIAL);
  assign attract_fire = stay_inicial && (attract_cnt == 32'(ATTRACT_PERIOD - 1));

  // Attract timer: gerar pulse every ATTRACT_PERIOD idle cycles, fade on the next
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      attract_cnt       <= '0;
      attract_fade_pend <= 1'b0;
      external          <= 1'b1;
    end else begin
      attract_cnt       <= (!stay_inicial || attract_fire) ? '0 : attract_cnt + 32'd1;
      attract_fade_pend <= attract_fire;
      external          <= (state_next == INICIAL);
    end
  end
`else
  logic unused_attract_period;

  assign attract_fire          = 1'b0;
  assign attract_fade_pend     = 1'b0;
  assign external              = 1'b0;
  assign unused_attract_period = (ATTRACT_PERIOD != 0);
`endif

endmodule
